// File: rtl/permutation_sequencer.sv
// Iterative Ascon permutation: one full round (constant addition, 5-bit S-box layer,
// linear diffusion) per clock over a 5x64-bit state, running p^a or p^b on request.
module permutation_sequencer #(
  parameter int A_ROUNDS = 12,
  parameter int B_ROUNDS = 6
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  // Round counts outside 1..12 would start the index past the last round.
  if (A_ROUNDS < 1 || A_ROUNDS > 12) begin : g_bad_a_rounds
    $error("permutation_sequencer: A_ROUNDS must be in 1..12");
  end
  if (B_ROUNDS < 1 || B_ROUNDS > 12) begin : g_bad_b_rounds
    $error("permutation_sequencer: B_ROUNDS must be in 1..12");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] START_A    = 4'(12 - A_ROUNDS);
  localparam logic [3:0] START_B    = 4'(12 - B_ROUNDS);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  logic [1:0]   fsm_reg;
  logic [319:0] state_reg;
  logic [3:0]   round_reg;
  logic [319:0] round_result;

  function automatic logic [7:0] round_constant(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'hf0;
      4'd1:    rc = 8'he1;
      4'd2:    rc = 8'hd2;
      4'd3:    rc = 8'hc3;
      4'd4:    rc = 8'hb4;
      4'd5:    rc = 8'ha5;
      4'd6:    rc = 8'h96;
      4'd7:    rc = 8'h87;
      4'd8:    rc = 8'h78;
      4'd9:    rc = 8'h69;
      4'd10:   rc = 8'h5a;
      4'd11:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Column S-box; bit 4 of the column is lane x0, bit 0 is lane x4.
  function automatic logic [4:0] sbox(input logic [4:0] col);
    logic [4:0] s;
    case (col)
      5'h00: s = 5'h04;  5'h01: s = 5'h0b;  5'h02: s = 5'h1f;  5'h03: s = 5'h14;
      5'h04: s = 5'h1a;  5'h05: s = 5'h15;  5'h06: s = 5'h09;  5'h07: s = 5'h02;
      5'h08: s = 5'h1b;  5'h09: s = 5'h05;  5'h0a: s = 5'h08;  5'h0b: s = 5'h12;
      5'h0c: s = 5'h1d;  5'h0d: s = 5'h03;  5'h0e: s = 5'h06;  5'h0f: s = 5'h1c;
      5'h10: s = 5'h1e;  5'h11: s = 5'h13;  5'h12: s = 5'h07;  5'h13: s = 5'h0e;
      5'h14: s = 5'h00;  5'h15: s = 5'h0d;  5'h16: s = 5'h11;  5'h17: s = 5'h18;
      5'h18: s = 5'h10;  5'h19: s = 5'h0c;  5'h1a: s = 5'h01;  5'h1b: s = 5'h19;
      5'h1c: s = 5'h16;  5'h1d: s = 5'h0a;  5'h1e: s = 5'h0f;  default: s = 5'h17;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned amt);
    return (x >> amt) | (x << (64 - amt));
  endfunction

  function automatic logic [319:0] substitution(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] y0, y1, y2, y3, y4;
    logic [4:0]  col;
    {x0, x1, x2, x3, x4} = s;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0; y4 = '0;
    for (int i = 0; i < 64; i++) begin
      col = sbox({x0[i], x1[i], x2[i], x3[i], x4[i]});
      {y0[i], y1[i], y2[i], y3[i], y4[i]} = col;
    end
    return {y0, y1, y2, y3, y4};
  endfunction

  function automatic logic [319:0] diffusion(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    {x0, x1, x2, x3, x4} = s;
    return {x0 ^ rotr(x0, 19) ^ rotr(x0, 28),
            x1 ^ rotr(x1, 61) ^ rotr(x1, 39),
            x2 ^ rotr(x2,  1) ^ rotr(x2,  6),
            x3 ^ rotr(x3, 10) ^ rotr(x3, 17),
            x4 ^ rotr(x4,  7) ^ rotr(x4, 41)};
  endfunction

  // The round constant lands in the low byte of lane x2.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [319:0] t;
    t = s;
    t[135:128] = s[135:128] ^ round_constant(idx);
    return diffusion(substitution(t));
  endfunction

  assign round_result = ascon_round(state_reg, round_reg);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_reg   <= ST_IDLE;
      state_reg <= '0;
      round_reg <= '0;
    end else begin
      case (fsm_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg <= state_i;
            round_reg <= mode_i ? START_B : START_A;
            fsm_reg   <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_reg <= round_result;
          if (round_reg == LAST_ROUND) begin
            fsm_reg <= ST_DONE;
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end
        ST_DONE: fsm_reg <= ST_IDLE;
        default: fsm_reg <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state_reg;
  assign round_o = round_reg;
  assign busy_o  = (fsm_reg == ST_RUN) || (fsm_reg == ST_DONE);
  assign done_o  = (fsm_reg == ST_DONE);

endmodule
